// File: rtl/counter_seg_display.sv
// counter_seg_display: binary-to-BCD conversion (sequential double-dabble,
// one bit per clock) feeding a time-multiplexed 7-segment display driver.
// Optional build macro: COUNTER_SEG_DISPLAY_LEADING_ZERO_BLANK_EN
//   defined   -> digits above the most significant nonzero digit are blank
//   undefined -> every digit shows its BCD value, leading zeros included
module counter_seg_display #(
  parameter int unsigned COUNTER_BITS   = 8,
  parameter int unsigned NUM_DIGITS     = 3,
  parameter int unsigned SCAN_DIVIDER   = 50000,
  parameter int unsigned SEG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [COUNTER_BITS-1:0] value_in,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic                    bcd_valid,
  output logic                    busy
);

  localparam int unsigned BCD_W   = 4 * NUM_DIGITS;
  localparam int unsigned TOT_W   = BCD_W + COUNTER_BITS;
  localparam int unsigned CNT_W   = $clog2(COUNTER_BITS + 1);
  localparam int unsigned PS_W    = $clog2(SCAN_DIVIDER);
  localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned MAX_VAL = (10 ** NUM_DIGITS) - 1;
  localparam logic [7:0]  SEG_BLANK = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  typedef enum logic [1:0] {IDLE, CONVERT, LOAD} state_t;

  state_t                  state, state_nxt;
  logic                    capture, shift_en, load_en;
  logic [COUNTER_BITS-1:0] shreg;
  logic [COUNTER_BITS-1:0] last_captured;
  logic [BCD_W-1:0]        acc;
  logic [BCD_W-1:0]        acc_adj;
  logic [TOT_W-1:0]        shifted;
  logic [CNT_W-1:0]        bit_cnt;
  logic                    ovf;
  logic                    ovf_disp;
  logic                    first_flag;

  logic [PS_W-1:0]         prescaler;
  logic [IDX_W-1:0]        digit_idx, idx_nxt;
  logic [3:0]              nib;
  logic                    blank_digit;
  logic [7:0]              seg_raw, seg_nxt;

  // Active-low segment pattern {dp,g,f,e,d,c,b,a}; A-F render blank
  function automatic logic [7:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0:    seg_decode = 8'hC0;
      4'd1:    seg_decode = 8'hF9;
      4'd2:    seg_decode = 8'hA4;
      4'd3:    seg_decode = 8'hB0;
      4'd4:    seg_decode = 8'h99;
      4'd5:    seg_decode = 8'h92;
      4'd6:    seg_decode = 8'h82;
      4'd7:    seg_decode = 8'hF8;
      4'd8:    seg_decode = 8'h80;
      4'd9:    seg_decode = 8'h90;
      default: seg_decode = 8'hFF;
    endcase
  endfunction

  assign busy = (state != IDLE);

  // Conversion FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state and datapath enables
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    shift_en  = 1'b0;
    load_en   = 1'b0;
    case (state)
      IDLE: begin
        if (first_flag || (value_in != last_captured)) begin
          capture   = 1'b1;
          state_nxt = CONVERT;
        end
      end
      CONVERT: begin
        shift_en = 1'b1;
        if (bit_cnt == CNT_W'(COUNTER_BITS - 1)) state_nxt = LOAD;
      end
      LOAD: begin
        load_en   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Double-dabble step: add 3 to nibbles >= 5, then shift {bcd, shreg} left
  always_comb begin
    acc_adj = acc;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    shifted = {acc_adj, shreg} << 1;
  end

  // Conversion datapath and result registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg         <= '0;
      last_captured <= '0;
      acc           <= '0;
      bit_cnt       <= '0;
      ovf           <= 1'b0;
      ovf_disp      <= 1'b0;
      first_flag    <= 1'b1;
      bcd_out       <= '0;
      bcd_valid     <= 1'b0;
    end else begin
      bcd_valid <= load_en;
      if (capture) begin
        shreg         <= value_in;
        last_captured <= value_in;
        ovf           <= (32'(value_in) > MAX_VAL);
        acc           <= '0;
        bit_cnt       <= '0;
        first_flag    <= 1'b0;
      end
      if (shift_en) begin
        // Accumulator keeps only NUM_DIGITS nibbles; carries out the top are dropped
        acc     <= shifted[TOT_W-1:COUNTER_BITS];
        shreg   <= shifted[COUNTER_BITS-1:0];
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
      if (load_en) begin
        bcd_out  <= acc;
        ovf_disp <= ovf;
      end
    end
  end

  // Next digit index and its segment pattern, taken from current bcd_out/ovf
  always_comb begin
    idx_nxt = (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
    nib     = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_nxt == IDX_W'(i)) nib = bcd_out[4*i +: 4];
    end
`ifdef COUNTER_SEG_DISPLAY_LEADING_ZERO_BLANK_EN
    blank_digit = (idx_nxt != '0);
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if ((IDX_W'(i) >= idx_nxt) && (bcd_out[4*i +: 4] != 4'd0)) blank_digit = 1'b0;
    end
`else
    blank_digit = 1'b0;
`endif
    if (ovf_disp)         seg_raw = 8'hBF;
    else if (blank_digit) seg_raw = 8'hFF;
    else                  seg_raw = seg_decode(nib);
    seg_nxt = (SEG_ACTIVE_LOW != 0) ? seg_raw : ~seg_raw;
  end

  // Scan prescaler; digit_sel and seg_out move together on the terminal count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescaler <= '0;
      digit_idx <= '0;
      digit_sel <= NUM_DIGITS'(1);
      seg_out   <= SEG_BLANK;
    end else if (prescaler == PS_W'(SCAN_DIVIDER - 1)) begin
      prescaler <= '0;
      digit_idx <= idx_nxt;
      digit_sel <= NUM_DIGITS'(1) << idx_nxt;
      seg_out   <= seg_nxt;
    end else begin
      prescaler <= prescaler + PS_W'(1);
    end
  end

endmodule

// File: tb/tb_counter_seg_display.sv
// Bench for counter_seg_display: scoreboard of expected BCD results checked
// on every bcd_valid pulse, plus scan/segment checks. Two instances: 3 digits
// (main) and 2 digits (overflow cases).
module tb_counter_seg_display;

`ifdef COUNTER_SEG_DISPLAY_LEADING_ZERO_BLANK_EN
  localparam logic [7:0] LZ = 8'hFF;
`else
  localparam logic [7:0] LZ = 8'hC0;
`endif

  logic        clk = 1'b0;
  logic        reset_n, reset2_n;
  logic [7:0]  value_in, value2;
  logic [7:0]  seg_out, seg2;
  logic [2:0]  digit_sel;
  logic [1:0]  digit_sel2;
  logic [11:0] bcd_out;
  logic [7:0]  bcd_out2;
  logic        bcd_valid, bcd_valid2, busy, busy2;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;
  logic [11:0] exp_q[$];
  logic [7:0]  exp_q2[$];

  always #5 clk = ~clk;

  counter_seg_display #(.COUNTER_BITS(8), .NUM_DIGITS(3), .SCAN_DIVIDER(4), .SEG_ACTIVE_LOW(1)) dut (
    .clk(clk), .reset_n(reset_n), .value_in(value_in), .seg_out(seg_out),
    .digit_sel(digit_sel), .bcd_out(bcd_out), .bcd_valid(bcd_valid), .busy(busy));

  counter_seg_display #(.COUNTER_BITS(8), .NUM_DIGITS(2), .SCAN_DIVIDER(4), .SEG_ACTIVE_LOW(1)) dut2 (
    .clk(clk), .reset_n(reset2_n), .value_in(value2), .seg_out(seg2),
    .digit_sel(digit_sel2), .bcd_out(bcd_out2), .bcd_valid(bcd_valid2), .busy(busy2));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitors: each bcd_valid pulse consumes one expected result
  always @(negedge clk) begin
    if (reset_n && bcd_valid) begin
      pulses++;
      check_eq("pending_expect", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check_eq("bcd_out", bcd_out, exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (reset2_n && bcd_valid2) begin
      check_eq("pending_expect2", 32'(exp_q2.size() > 0), 1);
      if (exp_q2.size() > 0) check_eq("bcd_out2", bcd_out2, exp_q2.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Counts negedges until bcd_valid; records busy in the first cycle
  task automatic wait_valid(input string tag, output int cyc, output logic busy_first);
    cyc = 0;
    busy_first = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) busy_first = busy;
    end while (!bcd_valid && cyc < 100);
    check_eq({tag, "_timeout"}, 32'(bcd_valid), 1);
  endtask

  task automatic wait_valid2(input string tag);
    int cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bcd_valid2 && cyc < 100);
    check_eq({tag, "_timeout"}, 32'(bcd_valid2), 1);
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_bcd_out"},   bcd_out, 0);
    check_eq({tag, "_bcd_valid"}, bcd_valid, 0);
    check_eq({tag, "_busy"},      busy, 0);
    check_eq({tag, "_digit_sel"}, digit_sel, 3'b001);
    check_eq({tag, "_seg_out"},   seg_out, 8'hFF);
  endtask

  task automatic check_disp(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2);
    logic [7:0] s [3];
    int n [3];
    int bad = 0;
    for (int i = 0; i < 3; i++) begin s[i] = 8'h00; n[i] = 0; end
    repeat (12) @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      case (digit_sel)
        3'b001:  begin s[0] = seg_out; n[0]++; end
        3'b010:  begin s[1] = seg_out; n[1]++; end
        3'b100:  begin s[2] = seg_out; n[2]++; end
        default: bad++;
      endcase
    end
    check_eq({tag, "_seg_d0"}, s[0], e0);
    check_eq({tag, "_seg_d1"}, s[1], e1);
    check_eq({tag, "_seg_d2"}, s[2], e2);
    check_eq({tag, "_hold_d0"}, n[0], 4);
    check_eq({tag, "_hold_d1"}, n[1], 4);
    check_eq({tag, "_hold_d2"}, n[2], 4);
    check_eq({tag, "_onehot"}, bad, 0);
  endtask

  task automatic check_disp2(input string tag, input logic [7:0] e0, input logic [7:0] e1);
    logic [7:0] s [2];
    int bad = 0;
    s[0] = 8'h00;
    s[1] = 8'h00;
    repeat (8) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      case (digit_sel2)
        2'b01:   s[0] = seg2;
        2'b10:   s[1] = seg2;
        default: bad++;
      endcase
    end
    check_eq({tag, "_seg_d0"}, s[0], e0);
    check_eq({tag, "_seg_d1"}, s[1], e1);
    check_eq({tag, "_onehot"}, bad, 0);
  endtask

  initial begin
    int   cyc;
    logic bf;
    int   p0;

    reset_n  = 1'b0;
    reset2_n = 1'b0;
    value_in = 8'd0;
    value2   = 8'd0;
    repeat (3) @(negedge clk);
    check_reset("por");

    // 1: first conversion after reset, value 0
    exp_q.push_back(12'h000);
    exp_q2.push_back(8'h00);
    reset_n  = 1'b1;
    reset2_n = 1'b1;
    wait_valid("t1", cyc, bf);
    check_eq("t1_latency", cyc, 10);
    check_eq("t1_busy_start", bf, 1);
    check_eq("t1_busy_at_valid", busy, 0);
    check_disp("t1", 8'hC0, LZ, LZ);

    // 2: full-scale 8-bit value
    value_in = 8'd255;
    exp_q.push_back(12'h255);
    wait_valid("t2", cyc, bf);
    check_eq("t2_latency", cyc, 10);
    check_eq("t2_busy_start", bf, 1);
    check_disp("t2", 8'h92, 8'h92, 8'hA4);

    // 3: input change during CONVERT is picked up after LOAD, never lost
    p0 = pulses;
    value_in = 8'd17;
    exp_q.push_back(12'h017);
    repeat (3) @(negedge clk);
    value_in = 8'd42;
    exp_q.push_back(12'h042);
    wait_valid("t3a", cyc, bf);
    wait_valid("t3b", cyc, bf);
    repeat (30) @(negedge clk);
    check_eq("t3_pulse_count", pulses - p0, 2);
    check_eq("t3_bcd_hold", bcd_out, 12'h042);

    // 4: two-digit instance, overflow boundaries
    value2 = 8'd123;
    exp_q2.push_back(8'h23);
    wait_valid2("t4a");
    check_disp2("t4a", 8'hBF, 8'hBF);
    value2 = 8'd100;
    exp_q2.push_back(8'h00);
    wait_valid2("t4b");
    check_disp2("t4b", 8'hBF, 8'hBF);
    value2 = 8'd99;
    exp_q2.push_back(8'h99);
    wait_valid2("t4c");
    check_disp2("t4c", 8'h90, 8'h90);
    check_eq("t4_busy2_idle", busy2, 0);

    // 5: reset in the middle of a conversion
    value_in = 8'd200;
    exp_q.push_back(12'h200);
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset("t5_abort");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_valid("t5", cyc, bf);
    check_eq("t5_latency", cyc, 10);
    check_disp("t5", 8'hC0, 8'hC0, 8'hA4);

    // 6: single-digit value, leading-zero handling
    value_in = 8'd7;
    exp_q.push_back(12'h007);
    wait_valid("t6", cyc, bf);
    check_disp("t6", 8'hF8, LZ, LZ);

    repeat (20) @(negedge clk);
    check_eq("queue_drained", exp_q.size(), 0);
    check_eq("queue2_drained", exp_q2.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
